uart_tx_fifo: RTL

Parametrised UART transmitter with an integrated transmit FIFO.
- Frame format set at elaboration time: 5–9 data bits, optional odd/even parity, 1 or 2 stop bits.
- Frames are sent back-to-back with no idle gap while the FIFO holds data.
- Sits between host/bus write logic and the serial TX pin; replaces the single-byte transmitter in new designs.

---
 rtl/uart_tx_fifo.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   UART transmitter with an integrated transmit FIFO. Frame format is fixed at
//   elaboration: DATA_BITS (5..9) data bits sent LSB first, optional odd/even
//   parity, STOP_BITS (1 or 2) stop bits. Queued words are sent back-to-back
//   with no idle gap between frames.
//
//   Optional feature macro: UART_TX_BREAK_EN
//     When defined, adds input txBreak. While it is high the line is forced low,
//     any frame in progress completes internally, and no new word is popped.
//
// Ports
//   clk       in   system clock, all logic on posedge
//   rst_n     in   asynchronous active-low reset
//   wrEn      in   push din into the FIFO when full is low
//   din       in   data word, LSB transmitted first
//   txBreak   in   (UART_TX_BREAK_EN only) force line low / hold off new frames
//   full      out  FIFO holds FIFO_DEPTH entries
//   count     out  FIFO occupancy
//   overflow  out  one-cycle pulse after a write attempted while full
//   busy      out  transmitter active or FIFO non-empty
//   txPin     out  serial line, idles high
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int CLOCK      = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wrEn,
    input  logic [DATA_BITS-1:0]        din,
`ifdef UART_TX_BREAK_EN
    input  logic                        txBreak,
`endif
    output logic                        full,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        overflow,
    output logic                        busy,
    output logic                        txPin
);

    localparam int CLKS_PER_BIT = CLOCK / BAUD;
    localparam int CLK_W        = $clog2(CLKS_PER_BIT);
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int CNT_W        = PTR_W + 1;

    localparam logic [CLK_W-1:0] CLK_LAST  = CLK_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic             PAR_EN    = (PARITY != 0);
    localparam logic             PAR_ODD   = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // FSM / datapath registers
    state_t               r_state;
    logic [CLK_W-1:0]     r_clk_cnt;
    logic [3:0]           r_bit_idx;   // data bit index, reused to count stop bits
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_parity;
    logic                 r_tx;
    logic                 r_busy;

    // FIFO registers
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic                 r_full;
    logic                 r_overflow;

    // Combinational next-state values
    state_t               w_state_nxt;
    logic [CLK_W-1:0]     w_clk_nxt;
    logic [3:0]           w_bit_nxt;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic                 w_par_nxt;
    logic                 w_tx_nxt;
    logic [CNT_W-1:0]     w_count_nxt;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_can_pop;
    logic                 w_bit_end;
    logic                 w_break;
    logic [DATA_BITS-1:0] w_head;
    logic                 w_head_par;

`ifdef UART_TX_BREAK_EN
    assign w_break = txBreak;
`else
    assign w_break = 1'b0;
`endif

    assign w_push     = wrEn && !r_full;
    assign w_can_pop  = (r_count != '0) && !w_break;
    assign w_bit_end  = (r_clk_cnt == CLK_LAST);
    assign w_head     = r_mem[r_rd_ptr];
    assign w_head_par = PAR_ODD ? ~(^w_head) : (^w_head);

    // -------------------------------------------------------------------------
    // Next-state logic. A pop is only ever requested from IDLE or from the last
    // cycle of STOP; both reload the frame the same way, so the reload is
    // applied once after the case.
    // -------------------------------------------------------------------------
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no path leaves a value held and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_clk_nxt   = r_clk_cnt + 1'b1;
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_parity;
        w_pop       = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_clk_nxt = '0;
                w_pop     = w_can_pop;
            end
            S_START: begin
                if (w_bit_end) begin
                    w_clk_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_clk_nxt   = '0;
                    w_shift_nxt = r_shift >> 1;   // next data bit moves to bit 0
                    if (r_bit_idx == DATA_LAST) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = PAR_EN ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_nxt = r_bit_idx + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_clk_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_clk_nxt = '0;
                    if (r_bit_idx == STOP_LAST) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = S_IDLE;
                        w_pop       = w_can_pop;  // zero-gap chaining
                    end else begin
                        w_bit_nxt = r_bit_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_clk_nxt   = '0;
                w_bit_nxt   = '0;
            end
        endcase

        if (w_pop) begin
            w_state_nxt = S_START;
            w_clk_nxt   = '0;
            w_bit_nxt   = '0;
            w_shift_nxt = w_head;
            w_par_nxt   = w_head_par;
        end
    end

    // Line level for the current state; registered below, so the pin trails
    // the state by one cycle while every bit keeps its full width.
    always_comb begin
        w_tx_nxt = 1'b1;
        case (r_state)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = r_shift[0];
            S_PARITY: w_tx_nxt = r_parity;
            default:  w_tx_nxt = 1'b1;
        endcase
        if (w_break) begin
            w_tx_nxt = 1'b0;
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential blocks use non-blocking '<=' so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_clk_cnt <= w_clk_nxt;
            r_bit_idx <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_parity  <= w_par_nxt;
            r_tx      <= w_tx_nxt;
            r_busy    <= (r_state != S_IDLE) || (r_count != '0);
        end
    end

    // -------------------------------------------------------------------------
    // FIFO control. A write while full is dropped even if a pop frees a slot
    // in the same cycle, which keeps overflow a pure function of full.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count    <= w_count_nxt;
            r_full     <= (w_count_nxt == CNT_FULL);
            r_overflow <= wrEn && r_full;
        end
    end

    // NOTE: the storage array has no reset; entries are only read after being
    // written, and a reset port on it would block mapping to RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    assign full     = r_full;
    assign count    = r_count;
    assign overflow = r_overflow;
    assign busy     = r_busy;
    assign txPin    = r_tx;

endmodule
